mem_access_stage: RTL

- MEM stage of the Lapido pipeline: consumer of the EX/MEM register outputs (ALUResult, memRead, memWrite, memToReg, registerFileWrite).
- Performs data-memory reads/writes over a req/ready handshake with variable wait states.
- Stalls the pipeline while an access is outstanding.
- Presents the write-back result (ALU value or load data) to the MEM/WB boundary.

---
 rtl/lapido_mem_pkg.sv | 21 ++
 rtl/mem_wait_timer.sv | 38 +++
 rtl/mem_access_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/lapido_mem_pkg.sv
// Shared definitions for the Lapido MEM stage.
// Contents: default bus widths, the FSM state type, the word-alignment mask
// and a helper that tests an address for word alignment.
package lapido_mem_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_REG_SEL_WIDTH = 4;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state timer for the MEM stage.
// Counts cycles spent waiting for memory and flags the last allowed cycle.
// Ports:
//   clock, reset  - rising-edge clock, asynchronous active-low reset
//   load          - clear the count (start of a new access)
//   inc           - one more wait cycle elapsed
//   expired       - the current wait cycle is the TIMEOUT_CYCLES-th one
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic inc,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Wait-cycle counter; saturates at the limit instead of wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= {CW{1'b0}};
    end else if (load) begin
      count <= {CW{1'b0}};
    end else if (inc && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  // count holds completed wait cycles, so the cycle that sees LAST is the final one.
  assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the Lapido pipeline.
// Either passes the ALU result through to write-back, or runs one data-memory
// access over a req/ready handshake while stalling the pipeline, with a
// timeout that aborts a stuck access as a bus error.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-low reset
//   ALUResult, storeData  - address / pass-through value, store data
//   memRead, memWrite     - load / store request
//   memToReg              - write-back source (1 = load data)
//   registerFileWrite     - destination register (0 = none)
//   memReq, memWe, memAddr, memWData - memory request side
//   memReady, memRData    - memory completion and read data
//   stall                 - freeze upstream registers
//   wbData, wbRegisterFileWrite, wbValid - write-back result
//   busError              - one-cycle error pulse
// Optional build macro MEM_ACCESS_PERF_EN adds stallCycles and accessCount
// saturating performance counters.
module mem_access_stage
  import lapido_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int REG_SEL_WIDTH  = DEFAULT_REG_SEL_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    ALUResult,
  input  logic [DATA_WIDTH-1:0]    storeData,
  input  logic                     memRead,
  input  logic                     memWrite,
  input  logic                     memToReg,
  input  logic [REG_SEL_WIDTH-1:0] registerFileWrite,
  output logic                     memReq,
  output logic                     memWe,
  output logic [DATA_WIDTH-1:0]    memAddr,
  output logic [DATA_WIDTH-1:0]    memWData,
  input  logic                     memReady,
  input  logic [DATA_WIDTH-1:0]    memRData,
  output logic                     stall,
  output logic [DATA_WIDTH-1:0]    wbData,
  output logic [REG_SEL_WIDTH-1:0] wbRegisterFileWrite,
  output logic                     wbValid,
  output logic                     busError
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [31:0]              stallCycles,
  output logic [31:0]              accessCount
`endif
);

  mem_state_t               state;
  mem_state_t               state_next;
  logic                     pass;
  logic                     issue;
  logic                     op_error;
  logic                     complete;
  logic                     timed_out;
  logic                     stall_int;
  logic                     timer_expired;
  logic [REG_SEL_WIDTH-1:0] dest_lat;
  logic                     to_reg_lat;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (issue),
    .inc    (state == WAIT),
    .expired(timer_expired)
  );

  // Next-state logic and decode of this cycle's retirement event.
  always_comb begin
    state_next = state;
    pass       = 1'b0;
    issue      = 1'b0;
    op_error   = 1'b0;
    complete   = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (!memRead && !memWrite) begin
          pass = 1'b1;
        end else if ((memRead ^ memWrite) && is_word_aligned(ALUResult[1:0])) begin
          issue      = 1'b1;
          state_next = WAIT;
        end else begin
          op_error = 1'b1;
        end
      end
      WAIT: begin
        // Ready takes priority over a timeout in the same cycle.
        if (memReady) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (timer_expired) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WAIT;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Stall covers the issuing cycle plus every wait cycle; forced low during reset
  // so an abandoned access releases the pipeline immediately.
  assign stall_int = (state == WAIT) || issue;
  assign stall     = reset && stall_int;

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Memory request, latched instruction context and write-back registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memReq              <= 1'b0;
      memWe               <= 1'b0;
      memAddr             <= {DATA_WIDTH{1'b0}};
      memWData            <= {DATA_WIDTH{1'b0}};
      wbData              <= {DATA_WIDTH{1'b0}};
      wbRegisterFileWrite <= {REG_SEL_WIDTH{1'b0}};
      wbValid             <= 1'b0;
      busError            <= 1'b0;
      dest_lat            <= {REG_SEL_WIDTH{1'b0}};
      to_reg_lat          <= 1'b0;
    end else begin
      wbValid  <= pass | op_error | complete | timed_out;
      busError <= op_error | timed_out;

      // wbData is only replaced by a real result; aborted instructions retire as nops.
      if (pass) begin
        wbData              <= ALUResult;
        wbRegisterFileWrite <= registerFileWrite;
      end else if (complete) begin
        wbData              <= to_reg_lat ? memRData : memAddr;
        wbRegisterFileWrite <= dest_lat;
      end else if (op_error || timed_out) begin
        wbRegisterFileWrite <= {REG_SEL_WIDTH{1'b0}};
      end

      if (issue) begin
        memReq     <= 1'b1;
        memWe      <= memWrite;
        memAddr    <= ALUResult;
        memWData   <= storeData;
        dest_lat   <= registerFileWrite;
        to_reg_lat <= memToReg;
      end else if (complete || timed_out) begin
        memReq <= 1'b0;
        memWe  <= 1'b0;
      end
    end
  end

`ifdef MEM_ACCESS_PERF_EN
  // Saturating counters of stalled cycles and completed handshakes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stallCycles <= 32'h0000_0000;
      accessCount <= 32'h0000_0000;
    end else begin
      if (stall_int && (stallCycles != 32'hFFFF_FFFF)) begin
        stallCycles <= stallCycles + 32'h0000_0001;
      end
      if (complete && (accessCount != 32'hFFFF_FFFF)) begin
        accessCount <= accessCount + 32'h0000_0001;
      end
    end
  end
`endif

endmodule
